matrix_3x3_gen: RTL and testbench
=================================

MATRIX_3X3_GEN -- requirements
Module: matrix_3x3_gen

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, the pixel width in bits.
REQ-002 SHALL have parameter IMG_WIDTH, default 1280, the active pixels per line.
REQ-003 SHALL have parameter IMG_HEIGHT, default 720, the active lines per frame.
REQ-004 SHALL have port clk  input  1  clock; all logic on rising edge.
REQ-005 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port in_vs  input  1  frame sync, active-high; a rising edge starts a new frame.
REQ-007 SHALL have port in_hs  input  1  line sync; delayed only, with no other effect.
REQ-008 SHALL have port in_de  input  1  pixel valid; one pixel per clk while high.
REQ-009 SHALL have port in_data  input  DATA_WIDTH  pixel value.
REQ-010 SHALL have ports out_vs, out_hs, out_de  output  1 each  in_vs, in_hs and in_de delayed 2 clk.
REQ-011 SHALL have port out_win  output  9*DATA_WIDTH  3x3 window, row-major: p11 in the MSBs, p33 in the LSBs.

Function
REQ-012 SHALL keep column counter x, width clog2(IMG_WIDTH); +1 per in_de cycle, saturating at IMG_WIDTH-1; cleared on the clk after an in_de falling edge.
REQ-013 SHALL keep row counter y, width clog2(IMG_HEIGHT); +1 on each in_de falling edge, saturating at IMG_HEIGHT-1; cleared on an in_vs rising edge (edge has priority over the increment).
REQ-014 SHALL have two internal line buffers, each IMG_WIDTH x DATA_WIDTH: L1 holds row y-1, L2 holds row y-2.
REQ-015 SHALL, on each in_de cycle, read L1[x] and L2[x] before writing, then write L1[x]<=in_data and L2[x]<=old L1[x].
REQ-016 SHALL form the window with the current input pixel (x,y) at p33: rows p1*=y-2, p2*=y-1, p3*=y; columns p*1=x-2, p*2=x-1, p*3=x.
REQ-017 SHALL apply a fixed 2-clk latency from in_de/in_data to out_de/out_win: stage 1 registers the RAM read and border flags, stage 2 shifts the column registers and drives out_win.
REQ-018 SHALL hold column shift registers only on in_de cycles; out_win holds its last value while out_de=0.
REQ-019 SHALL treat out-of-frame taps (y<2 for rows, x<2 for columns) per REQ-027/REQ-028.
REQ-020 SHALL, when in_de exceeds IMG_WIDTH pixels in a line, keep outputting windows with all extra pixels written to address IMG_WIDTH-1.
REQ-021 SHALL treat an in_de gap within a line as end of line: y increments and x restarts at 0.
REQ-022 SHALL, on simultaneous in_vs rising edge and in_de falling edge, set y=0.

Reset
REQ-023 SHALL, on rst_n low, clear x, y, all pipeline registers, out_vs/out_hs/out_de and out_win to 0 asynchronously.
REQ-024 SHALL NOT clear line buffer contents on reset; border handling masks stale data.
REQ-025 SHALL, after reset is released mid-frame, treat the next line as y=0.

Configuration
REQ-026 SHALL compile border replication in or out with macro MATRIX_BORDER_REPLICATE_EN.
REQ-027 SHALL, with the macro defined, replicate edges: for y=0 rows y-1 and y-2 take row y; for y=1 row y-2 takes row y-1; for x=0 columns x-1 and x-2 take column x; for x=1 column x-2 takes column x-1.
REQ-028 SHALL, without the macro, output 0 for every out-of-frame tap.

Verification
REQ-029 SHALL cover: IMG_WIDTH=4, IMG_HEIGHT=4, frame pixel value = 10*y+x, macro off -> window at (2,2) = 0,1,2 / 10,11,12 / 20,21,22, and out_de rises exactly 2 clk after in_de.
REQ-030 SHALL cover: same frame with the macro on -> window at (0,0) = all 0; window at (1,0) = 0,0,1 in every row.
REQ-031 SHALL cover: same frame with the macro off -> window at (0,1) = row1 0,0,0; row2 0,0,0; row3 0,0,10.
REQ-032 SHALL cover: a 6-pixel line with IMG_WIDTH=4 -> x holds at 3, no out-of-range write, and the next line window at (3,1) reads row0 col3 = last written pixel 5.
REQ-033 SHALL cover: rst_n pulsed low mid-line -> all outputs 0 within the same clk; the next line is processed as y=0 (rows y-1 and y-2 are 0 with the macro off).
REQ-034 SHALL cover: in_vs rising edge coincident with the last in_de falling edge -> the next line is y=0; in_vs, in_hs and in_de all appear on the outputs delayed exactly 2 clk.

Source files
------------

// File: rtl/matrix_3x3_gen_if.sv
// Pixel stream bundle for matrix_3x3_gen: sync/valid/data in, delayed sync and window out.
// master drives the raster stream; slave is the window generator.
interface matrix_3x3_gen_if #(
  parameter int DATA_WIDTH = 8
);
  logic                    in_vs;
  logic                    in_hs;
  logic                    in_de;
  logic [DATA_WIDTH-1:0]   in_data;
  logic                    out_vs;
  logic                    out_hs;
  logic                    out_de;
  logic [9*DATA_WIDTH-1:0] out_win;

  modport master (
    output in_vs, in_hs, in_de, in_data,
    input  out_vs, out_hs, out_de, out_win
  );

  modport slave (
    input  in_vs, in_hs, in_de, in_data,
    output out_vs, out_hs, out_de, out_win
  );
endinterface

// File: rtl/matrix_3x3_gen.sv
// 3x3 sliding window generator over a raster pixel stream, 2-clk latency.
// Define MATRIX_BORDER_REPLICATE_EN to replicate edges instead of zero padding.
module matrix_3x3_gen #(
  parameter int DATA_WIDTH = 8,
  parameter int IMG_WIDTH  = 1280,
  parameter int IMG_HEIGHT = 720
) (
  input logic             clk,
  input logic             rst_n,
  matrix_3x3_gen_if.slave px
);
  localparam int XW = (IMG_WIDTH > 1) ? $clog2(IMG_WIDTH) : 1;
  localparam int YW = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;
  localparam logic [XW-1:0] X_MAX = XW'(IMG_WIDTH - 1);
  localparam logic [YW-1:0] Y_MAX = YW'(IMG_HEIGHT - 1);
  localparam logic [XW-1:0] X_ONE = XW'(1);
  localparam logic [YW-1:0] Y_ONE = YW'(1);

`ifdef MATRIX_BORDER_REPLICATE_EN
  localparam bit REP = 1'b1;
`else
  localparam bit REP = 1'b0;
`endif

  typedef logic [DATA_WIDTH-1:0] pix_t;
  typedef struct packed {
    pix_t top;
    pix_t mid;
    pix_t bot;
  } col_t;

  logic [XW-1:0] x;
  logic [YW-1:0] y;
  logic [1:0]    vs_sr;
  logic [1:0]    hs_sr;
  logic [1:0]    de_sr;
  logic          vs_rise;
  logic          de_fall;

  pix_t l1 [IMG_WIDTH];
  pix_t l2 [IMG_WIDTH];

  col_t s1_col;
  logic s1_x0, s1_x1, s1_y0, s1_y1;

  col_t col_a, col_b;
  col_t ncol, w1, w2, w3;
  logic [9*DATA_WIDTH-1:0] win;

  assign vs_rise = px.in_vs & ~vs_sr[0];
  assign de_fall = ~px.in_de & de_sr[0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x <= '0;
      y <= '0;
    end else begin
      if (!px.in_de) x <= '0;
      else if (x != X_MAX) x <= x + X_ONE;
      if (vs_rise) y <= '0;
      else if (de_fall && y != Y_MAX) y <= y + Y_ONE;
    end
  end

  // Line buffers hold no reset; stale rows are masked by the border flags.
  always_ff @(posedge clk) begin
    if (px.in_de) begin
      l1[x] <= px.in_data;
      l2[x] <= l1[x];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vs_sr  <= '0;
      hs_sr  <= '0;
      de_sr  <= '0;
      s1_col <= '0;
      s1_x0  <= 1'b0;
      s1_x1  <= 1'b0;
      s1_y0  <= 1'b0;
      s1_y1  <= 1'b0;
    end else begin
      vs_sr <= {vs_sr[0], px.in_vs};
      hs_sr <= {hs_sr[0], px.in_hs};
      de_sr <= {de_sr[0], px.in_de};
      if (px.in_de) begin
        s1_col.top <= l2[x];
        s1_col.mid <= l1[x];
        s1_col.bot <= px.in_data;
        s1_x0      <= (x == '0);
        s1_x1      <= (x == X_ONE);
        s1_y0      <= (y == '0);
        s1_y1      <= (y == Y_ONE);
      end
    end
  end

  always_comb begin
    ncol = s1_col;
    unique case (1'b1)
      s1_y0: begin
        ncol.top = REP ? s1_col.bot : '0;
        ncol.mid = REP ? s1_col.bot : '0;
      end
      s1_y1:   ncol.top = REP ? s1_col.mid : '0;
      default: ;
    endcase
    w3 = ncol;
    w2 = col_a;
    w1 = col_b;
    unique case (1'b1)
      s1_x0: begin
        w2 = REP ? ncol : '0;
        w1 = REP ? ncol : '0;
      end
      s1_x1:   w1 = REP ? col_a : '0;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_a <= '0;
      col_b <= '0;
      win   <= '0;
    end else if (de_sr[0]) begin
      col_a <= ncol;
      col_b <= col_a;
      win   <= {w1.top, w2.top, w3.top,
                w1.mid, w2.mid, w3.mid,
                w1.bot, w2.bot, w3.bot};
    end
  end

  assign px.out_vs  = vs_sr[1];
  assign px.out_hs  = hs_sr[1];
  assign px.out_de  = de_sr[1];
  assign px.out_win = win;
endmodule

// File: tb/tb_matrix_3x3_gen.sv
// Directed bench for matrix_3x3_gen on a 4x4 image, pixel value 10*y+x.
// Expectations follow MATRIX_BORDER_REPLICATE_EN when it is defined.
module tb_matrix_3x3_gen;
  logic clk;
  logic rst_n;
  int   nvec;
  int   nerr;
  int   rst_cnt;
  logic [2:0] h1, h2;
  logic [71:0] cap [$];

  matrix_3x3_gen_if #(.DATA_WIDTH(8)) vif ();

  matrix_3x3_gen #(
    .DATA_WIDTH(8),
    .IMG_WIDTH (4),
    .IMG_HEIGHT(4)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .px   (vif)
  );

  typedef struct {
    string       name;
    int          idx;
    logic [71:0] exp;
  } vec_t;

  vec_t tbl [8];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [75:0] act,
                     input logic [75:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_win(input string name, input int idx,
                         input logic [71:0] exp);
    if (idx >= cap.size()) begin
      nvec++;
      nerr++;
      $display("FAIL %s: window %0d missing (%0d captured) expected %h",
               name, idx, cap.size(), exp);
    end else begin
      chk(name, 76'(cap[idx]), 76'(exp));
    end
  endtask

  function automatic logic [71:0] w9(input int a, input int b, input int c,
                                     input int d, input int e, input int f,
                                     input int g, input int h, input int i);
    return {8'(a), 8'(b), 8'(c), 8'(d), 8'(e), 8'(f), 8'(g), 8'(h), 8'(i)};
  endfunction

  // Output syncs must equal the inputs seen two cycles earlier.
  always @(negedge clk) begin
    if (!rst_n) rst_cnt = 0;
    else if (rst_cnt < 3) rst_cnt++;
    if (rst_cnt >= 3)
      chk("sync_dly", 76'({vif.out_vs, vif.out_hs, vif.out_de}), 76'(h2));
    h2 = h1;
    h1 = {vif.in_vs, vif.in_hs, vif.in_de};
    if (vif.out_de) cap.push_back(vif.out_win);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic start_frame();
    vif.in_vs = 1'b1;
    repeat (2) step();
    vif.in_vs = 1'b0;
    repeat (2) step();
  endtask

  task automatic drive_line(input int n, input int base, input bit vs_end);
    vif.in_hs = 1'b1;
    step();
    vif.in_hs = 1'b0;
    step();
    for (int i = 0; i < n; i++) begin
      vif.in_de   = 1'b1;
      vif.in_data = 8'(base + i);
      step();
    end
    vif.in_de   = 1'b0;
    vif.in_data = '0;
    if (vs_end) vif.in_vs = 1'b1;
    repeat (3) step();
    vif.in_vs = 1'b0;
    repeat (2) step();
  endtask

  initial begin
    nvec        = 0;
    nerr        = 0;
    rst_cnt     = 0;
    h1          = '0;
    h2          = '0;
    rst_n       = 1'b0;
    vif.in_vs   = 1'b0;
    vif.in_hs   = 1'b0;
    vif.in_de   = 1'b0;
    vif.in_data = '0;

`ifdef MATRIX_BORDER_REPLICATE_EN
    tbl[0] = '{"w00", 0,  w9(0, 0, 0, 0, 0, 0, 0, 0, 0)};
    tbl[1] = '{"w10", 1,  w9(0, 0, 1, 0, 0, 1, 0, 0, 1)};
    tbl[2] = '{"w30", 3,  w9(1, 2, 3, 1, 2, 3, 1, 2, 3)};
    tbl[3] = '{"w01", 4,  w9(0, 0, 0, 0, 0, 0, 10, 10, 10)};
    tbl[4] = '{"w12", 9,  w9(0, 0, 1, 10, 10, 11, 20, 20, 21)};
    tbl[5] = '{"w22", 10, w9(0, 1, 2, 10, 11, 12, 20, 21, 22)};
    tbl[6] = '{"w03", 12, w9(10, 10, 10, 20, 20, 20, 30, 30, 30)};
    tbl[7] = '{"w33", 15, w9(11, 12, 13, 21, 22, 23, 31, 32, 33)};
`else
    tbl[0] = '{"w00", 0,  w9(0, 0, 0, 0, 0, 0, 0, 0, 0)};
    tbl[1] = '{"w10", 1,  w9(0, 0, 0, 0, 0, 0, 0, 0, 1)};
    tbl[2] = '{"w30", 3,  w9(0, 0, 0, 0, 0, 0, 1, 2, 3)};
    tbl[3] = '{"w01", 4,  w9(0, 0, 0, 0, 0, 0, 0, 0, 10)};
    tbl[4] = '{"w12", 9,  w9(0, 0, 1, 0, 10, 11, 0, 20, 21)};
    tbl[5] = '{"w22", 10, w9(0, 1, 2, 10, 11, 12, 20, 21, 22)};
    tbl[6] = '{"w03", 12, w9(0, 0, 10, 0, 0, 20, 0, 0, 30)};
    tbl[7] = '{"w33", 15, w9(11, 12, 13, 21, 22, 23, 31, 32, 33)};
`endif

    repeat (3) step();
    chk("reset_state", 76'({vif.out_vs, vif.out_hs, vif.out_de, vif.out_win}), '0);
    rst_n = 1'b1;
    repeat (3) step();

    // Full 4x4 frame
    cap.delete();
    start_frame();
    for (int r = 0; r < 4; r++) drive_line(4, 10 * r, 1'b0);
    for (int i = 0; i < 8; i++) chk_win(tbl[i].name, tbl[i].idx, tbl[i].exp);
    chk("frame_count", 76'(cap.size()), 76'(16));

    // Single pixel: out_de must appear exactly two cycles later
    vif.in_de   = 1'b1;
    vif.in_data = 8'd99;
    chk("lat_c0", 76'(vif.out_de), 76'(0));
    step();
    vif.in_de = 1'b0;
    chk("lat_c1", 76'(vif.out_de), 76'(0));
    step();
    chk("lat_c2", 76'(vif.out_de), 76'(1));
    step();
    chk("lat_c3", 76'(vif.out_de), 76'(0));
    repeat (3) step();

    // Over-long line: x saturates, extra pixels land at the last column
    cap.delete();
    start_frame();
    drive_line(6, 0, 1'b0);
    drive_line(4, 10, 1'b0);
`ifdef MATRIX_BORDER_REPLICATE_EN
    chk_win("long_x3", 5, w9(3, 4, 5, 3, 4, 5, 3, 4, 5));
    chk_win("long_w31", 9, w9(1, 2, 5, 1, 2, 5, 11, 12, 13));
`else
    chk_win("long_x3", 5, w9(0, 0, 0, 0, 0, 0, 3, 4, 5));
    chk_win("long_w31", 9, w9(0, 0, 0, 1, 2, 5, 11, 12, 13));
`endif

    // Reset mid-line, next line restarts at y=0
    start_frame();
    drive_line(4, 0, 1'b0);
    vif.in_hs = 1'b1;
    step();
    vif.in_hs = 1'b0;
    step();
    vif.in_de   = 1'b1;
    vif.in_data = 8'd10;
    step();
    vif.in_data = 8'd11;
    step();
    rst_n       = 1'b0;
    vif.in_de   = 1'b0;
    vif.in_data = '0;
    #1;
    chk("rst_async", 76'({vif.out_vs, vif.out_hs, vif.out_de, vif.out_win}), '0);
    repeat (2) step();
    rst_n = 1'b1;
    repeat (3) step();
    cap.delete();
    drive_line(4, 20, 1'b0);
`ifdef MATRIX_BORDER_REPLICATE_EN
    chk_win("rst_w20", 2, w9(20, 21, 22, 20, 21, 22, 20, 21, 22));
`else
    chk_win("rst_w20", 2, w9(0, 0, 0, 0, 0, 0, 20, 21, 22));
`endif

    // Frame sync coincident with the last falling in_de
    start_frame();
    drive_line(4, 0, 1'b0);
    drive_line(4, 10, 1'b1);
    cap.delete();
    drive_line(4, 30, 1'b0);
`ifdef MATRIX_BORDER_REPLICATE_EN
    chk_win("vs_w20", 2, w9(30, 31, 32, 30, 31, 32, 30, 31, 32));
`else
    chk_win("vs_w20", 2, w9(0, 0, 0, 0, 0, 0, 30, 31, 32));
`endif

    repeat (4) step();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
